// File: rtl/hash_writeback_if.sv
// Hash writeback bus: digest capture input and memory write port.
// master = the writeback block, slave = hash core / memory arbiter side.
interface hash_writeback_if #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned ADDR_W     = 16
);
    logic                    capture;
    logic [32*NUM_NONCES-1:0] hout_vec;
    logic [ADDR_W-1:0]       output_addr;
    logic                    mem_grant;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [31:0]             mem_write_data;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    modport master (
        input  capture, hout_vec, output_addr, mem_grant,
        output mem_we, mem_addr, mem_write_data, busy, done, overrun
    );

    modport slave (
        output capture, hout_vec, output_addr, mem_grant,
        input  mem_we, mem_addr, mem_write_data, busy, done, overrun
    );
endinterface

// File: rtl/hash_writeback.sv
// Captures NUM_NONCES digest words on a strobe and writes them to consecutive
// memory addresses, one word per granted cycle.
module hash_writeback #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned ADDR_W     = 16
) (
    input logic                 clk,
    input logic                 reset,
    hash_writeback_if.master    bus_io
);
    localparam int unsigned IdxW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NONCES - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       buf_q [NUM_NONCES];
    logic              write_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    logic              accept;
    logic [IdxW-1:0]   idx_nxt;

    // A capture is only taken when no job is being written out.
    assign accept  = bus_io.capture && (state_q != StWrite);
    assign idx_nxt = idx_q + IdxW'(1);

    // Digest buffer: loaded on an accepted capture, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(NUM_NONCES); i++) begin
                buf_q[i] <= bus_io.hout_vec[32*i +: 32];
            end
        end
    end

    // Control FSM with registered address/data/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        state_q <= StWrite;
                        idx_q   <= '0;
                        write_q <= 1'b1;
                        busy_q  <= 1'b1;
                        // Address is base + idx, tracked incrementally.
                        addr_q  <= bus_io.output_addr;
                        data_q  <= bus_io.hout_vec[31:0];
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StWrite: begin
                    if (bus_io.capture) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus_io.mem_grant) begin
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            write_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_nxt;
                            addr_q <= addr_q + ADDR_W'(1);
                            data_q <= buf_q[idx_nxt];
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe follows the grant only while a job is in flight.
    assign bus_io.mem_we         = write_q & bus_io.mem_grant;
    assign bus_io.mem_addr       = addr_q;
    assign bus_io.mem_write_data = data_q;
    assign bus_io.busy           = busy_q;
    assign bus_io.done           = done_q;
    assign bus_io.overrun        = overrun_q;
endmodule

// File: tb/tb_hash_writeback.sv
// Scoreboard bench for hash_writeback: driver pushes expectations from a
// job-level model, a negedge monitor pops and compares.
module tb_hash_writeback;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 16;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   running;

    hash_writeback_if #(.NUM_NONCES(N), .ADDR_W(AW)) bus ();

    hash_writeback #(.NUM_NONCES(N), .ADDR_W(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: job-level view (words left, base, next index).
    wr_t          wq [$];
    logic [2:0]   sq [$];
    logic [31:0]  mwords [N];
    logic [AW-1:0] mbase;
    int           midx;
    int           rem;
    bit           done_now;
    bit           ovr;

    function automatic void model_step(bit rs, bit cap, bit gr,
                                       logic [32*N-1:0] hv, logic [AW-1:0] oa);
        bit  writing;
        bit  nd;
        wr_t w;
        if (rs) begin
            sq.push_back(3'b000);
            rem = 0;
            done_now = 0;
            ovr = 0;
            return;
        end
        writing = (rem > 0);
        sq.push_back({writing || done_now, ovr, done_now});
        nd = 0;
        if (writing) begin
            if (gr) begin
                w.cyc  = cyc;
                w.addr = AW'(int'(mbase) + midx);
                w.data = mwords[midx];
                wq.push_back(w);
                midx++;
                rem--;
                if (rem == 0) nd = 1;
            end
            if (cap) ovr = 1;
        end else if (cap) begin
            for (int i = 0; i < int'(N); i++) mwords[i] = hv[32*i +: 32];
            mbase = oa;
            midx  = 0;
            rem   = N;
        end
        done_now = nd;
    endfunction

    task automatic drive(input bit rs, input bit cap, input bit gr,
                         input logic [32*N-1:0] hv, input logic [AW-1:0] oa);
        @(posedge clk);
        #1;
        reset           = rs;
        bus.capture     = cap;
        bus.mem_grant   = gr;
        bus.hout_vec    = hv;
        bus.output_addr = oa;
        model_step(rs, cap, gr, hv, oa);
    endtask

    function automatic logic [32*N-1:0] rand_hv();
        logic [32*N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [32*N-1:0] seq_hv();
        logic [32*N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[32*i +: 32] = 32'hA000_0000 + 32'(i);
        return v;
    endfunction

    function automatic logic [32*N-1:0] fill_hv(logic [31:0] d);
        logic [32*N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[32*i +: 32] = d;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1, rand_hv(), AW'($urandom));
    endtask

    // Monitor: per-cycle status plus expected write for this cycle, if any.
    always @(negedge clk) begin
        if (running) begin
            logic [2:0] es;
            bit         ewe;
            wr_t        w;
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL status_underflow cyc=%0d got nothing queued", cyc);
            end else begin
                es = sq.pop_front();
                if ({bus.busy, bus.overrun, bus.done} !== es) begin
                    errors++;
                    $display("FAIL status cyc=%0d got busy/ovr/done=%b want %b",
                             cyc, {bus.busy, bus.overrun, bus.done}, es);
                end
            end
            ewe = (wq.size() > 0) && (wq[0].cyc == cyc);
            checks++;
            if (bus.mem_we !== ewe) begin
                errors++;
                $display("FAIL mem_we cyc=%0d got %b want %b", cyc, bus.mem_we, ewe);
            end
            if (ewe) begin
                w = wq.pop_front();
                if (bus.mem_we === 1'b1) begin
                    checks++;
                    if (bus.mem_addr !== w.addr || bus.mem_write_data !== w.data) begin
                        errors++;
                        $display("FAIL write cyc=%0d got %h:%h want %h:%h", cyc,
                                 bus.mem_addr, bus.mem_write_data, w.addr, w.data);
                    end
                end
            end
            if (reset) begin
                checks++;
                if (bus.mem_addr !== '0 || bus.mem_write_data !== '0) begin
                    errors++;
                    $display("FAIL reset_regs cyc=%0d got %h:%h want 0:0", cyc,
                             bus.mem_addr, bus.mem_write_data);
                end
            end
        end
    end

    initial begin
        bit found;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        rem      = 0;
        done_now = 0;
        ovr      = 0;
        midx     = 0;
        mbase    = '0;
        reset           = 1'b1;
        bus.capture     = 1'b0;
        bus.mem_grant   = 1'b0;
        bus.hout_vec    = '0;
        bus.output_addr = '0;
        running  = 1'b1;

        // Reset state.
        for (int k = 0; k < 3; k++) drive(1, 0, 0, '0, '0);
        idle(2);

        // Basic job, continuous grant.
        drive(0, 1, 1, seq_hv(), 16'h0100);
        idle(20);

        // Grant stalls on relative cycles 3, 4 and 9.
        for (int r = 0; r < 24; r++)
            drive(0, r == 0, !(r == 3 || r == 4 || r == 9), seq_hv(), 16'h0100);

        // Address wrap.
        drive(0, 1, 1, rand_hv(), 16'hFFFE);
        idle(20);

        // Back-to-back: second capture lands in the done cycle.
        drive(0, 1, 1, seq_hv(), 16'h0100);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (done_now) begin
                drive(0, 1, 1, rand_hv(), 16'h0200);
                found = 1;
            end else begin
                drive(0, 0, 1, rand_hv(), 16'h0300);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_timeout got no done within 40 cycles want done");
        end
        idle(20);

        // Overrun: capture with different data 5 cycles into a job.
        for (int r = 0; r < 22; r++)
            drive(0, r == 0 || r == 5, 1, (r == 5) ? fill_hv(32'hDEADBEEF) : seq_hv(),
                  (r == 5) ? 16'h0900 : 16'h0400);
        // Reset mid-job at relative cycle 8, then a fresh full job.
        for (int r = 0; r < 32; r++)
            drive(r == 8 || r == 9, r == 0 || r == 10, 1, rand_hv(), AW'($urandom));

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++)
            drive($urandom_range(199) == 0, $urandom_range(7) == 0,
                  $urandom_range(3) != 0, rand_hv(), AW'($urandom));
        idle(40);

        @(negedge clk);
        #1;
        running = 1'b0;
        checks++;
        if (wq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d writes %0d status left want 0 0",
                     wq.size(), sq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
